abr_intr_sched: RTL and testbench

ABR_INTR_SCHED -- requirements
Module: abr_intr_sched

---
 rtl/abr_intr_sched.sv | 174 +++++++++++++++++
 tb/tb_abr_intr_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/abr_intr_sched.sv
// abr_intr_sched: collects level interrupts from NumSrc blocks, picks the
// highest-priority asserted source (round-robin among equal priorities),
// optionally coalesces before raising irq, and tracks a single host
// claim/complete handshake.
module abr_intr_sched #(
    parameter int NumSrc = 8,
    parameter int PrioW  = 2,
    parameter int CoalW  = 8,
    parameter int IdW    = $clog2(NumSrc)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumSrc-1:0]       intr_i,
    input  logic [NumSrc*PrioW-1:0] prio_i,
    input  logic [CoalW-1:0]        coal_cycles_i,
    input  logic                    claim_i,
    input  logic                    complete_i,
    input  logic [IdW-1:0]          complete_id_i,
    output logic                    irq_o,
    output logic [IdW-1:0]          irq_id_o,
    output logic                    busy_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COAL    = 2'd1,
        ST_PEND    = 2'd2,
        ST_CLAIMED = 2'd3
    } state_e;

    state_e            state_r;
    logic [CoalW-1:0]  cnt_r;
    logic [IdW-1:0]    rr_ptr_r;
    logic [IdW-1:0]    claimed_id_r;
    logic              irq_r;
    logic [IdW-1:0]    irq_id_r;
    logic              busy_r;
    logic              err_r;

    logic [PrioW-1:0]  prio_a_s [NumSrc];
    logic              found_s;
    logic [PrioW-1:0]  best_prio_s;
    logic [IdW-1:0]    best_id_s;
    logic [IdW-1:0]    rr_next_s;
    logic              id_match_s;

    // Unpack the flat priority bus into one entry per source.
    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            prio_a_s[i] = prio_i[i*PrioW +: PrioW];
        end
    end

    // Arbiter: walk sources upward from rr_ptr with wrap; a strictly higher
    // priority replaces the current pick, so ties keep the first one found.
    always_comb begin
        int             idx_v;
        logic [IdW-1:0] idx_s;
        found_s     = 1'b0;
        best_prio_s = {PrioW{1'b0}};
        best_id_s   = {IdW{1'b0}};
        idx_v       = 0;
        idx_s       = {IdW{1'b0}};
        for (int k = 0; k < NumSrc; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            idx_v = (idx_v >= NumSrc) ? (idx_v - NumSrc) : idx_v;
            idx_s = IdW'(idx_v);
            if (intr_i[idx_s] && (!found_s || (prio_a_s[idx_s] > best_prio_s))) begin
                found_s     = 1'b1;
                best_prio_s = prio_a_s[idx_s];
                best_id_s   = idx_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Round-robin pointer after a completion and the completion ID check.
    always_comb begin
        if (claimed_id_r == IdW'(NumSrc - 1)) begin
            rr_next_s = {IdW{1'b0}};
        end else begin
            rr_next_s = claimed_id_r + {{(IdW-1){1'b0}}, 1'b1};
        end
        id_match_s = (complete_id_i == claimed_id_r);
    end

    // Scheduler FSM with all host-visible outputs registered.
    // The detection cycle in IDLE counts as the first coalescing cycle, so
    // COAL hands over to PEND once the counter is down to 2; irq_o then rises
    // exactly coal_cycles_i cycles after the first eligible source.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CoalW{1'b0}};
            rr_ptr_r     <= {IdW{1'b0}};
            claimed_id_r <= {IdW{1'b0}};
            irq_r        <= 1'b0;
            irq_id_r     <= {IdW{1'b0}};
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    err_r <= claim_i | complete_i;
                    if (|intr_i) begin
                        if (~|coal_cycles_i) begin
                            state_r  <= ST_PEND;
                            irq_r    <= 1'b1;
                            irq_id_r <= best_id_s;
                        end else begin
                            state_r <= ST_COAL;
                            cnt_r   <= coal_cycles_i;
                        end
                    end
                end
                ST_COAL: begin
                    err_r <= claim_i | complete_i;
                    if (~|intr_i) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CoalW{1'b0}};
                    end else if (cnt_r <= CoalW'(2)) begin
                        state_r  <= ST_PEND;
                        cnt_r    <= {CoalW{1'b0}};
                        irq_r    <= 1'b1;
                        irq_id_r <= best_id_s;
                    end else begin
                        cnt_r <= cnt_r - CoalW'(1);
                    end
                end
                ST_PEND: begin
                    err_r <= complete_i;
                    if (claim_i) begin
                        // Claim uses the ID the host saw, even if that source
                        // has just deasserted.
                        state_r      <= ST_CLAIMED;
                        claimed_id_r <= irq_id_r;
                        irq_r        <= 1'b0;
                        busy_r       <= 1'b1;
                    end else if (~|intr_i) begin
                        state_r <= ST_IDLE;
                        irq_r   <= 1'b0;
                    end else begin
                        irq_r    <= 1'b1;
                        irq_id_r <= best_id_s;
                    end
                end
                ST_CLAIMED: begin
                    irq_id_r <= claimed_id_r;
                    err_r    <= claim_i | (complete_i & ~id_match_s);
                    if (complete_i && id_match_s) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        rr_ptr_r <= rr_next_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CoalW{1'b0}};
                    irq_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o    = irq_r;
    assign irq_id_o = irq_id_r;
    assign busy_o   = busy_r;
    assign err_o    = err_r;

endmodule

// File: tb/tb_abr_intr_sched.sv
// Directed self-checking bench for abr_intr_sched (default parameters).
module tb_abr_intr_sched;

    localparam int NumSrc = 8;
    localparam int PrioW  = 2;
    localparam int CoalW  = 8;
    localparam int IdW    = 3;

    logic                    clk;
    logic                    rst;
    logic [NumSrc-1:0]       intr;
    logic [NumSrc*PrioW-1:0] prio;
    logic [CoalW-1:0]        coal;
    logic                    claim;
    logic                    complete;
    logic [IdW-1:0]          complete_id;
    logic                    irq;
    logic [IdW-1:0]          irq_id;
    logic                    busy;
    logic                    err;

    int checks;
    int failures;

    abr_intr_sched #(
        .NumSrc(NumSrc), .PrioW(PrioW), .CoalW(CoalW), .IdW(IdW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .intr_i(intr), .prio_i(prio),
        .coal_cycles_i(coal), .claim_i(claim), .complete_i(complete),
        .complete_id_i(complete_id), .irq_o(irq), .irq_id_o(irq_id),
        .busy_o(busy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; intr = '0; prio = '0; coal = '0;
        claim = 1'b0; complete = 1'b0; complete_id = '0;
        tick(); tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        checks++; if (irq_id !== 3'd0) begin failures++; $display("FAIL reset_id: got %0d expected 0", irq_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        intr = 8'h04;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq: got %0b expected 1", irq); end
        checks++; if (irq_id !== 3'd2) begin failures++; $display("FAIL basic_id: got %0d expected 2", irq_id); end
        tick(); tick();
        claim = 1'b1;
        tick();
        claim = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL basic_claim_irq: got %0b expected 0", irq); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_claim_busy: got %0b expected 1", busy); end
        checks++; if (irq_id !== 3'd2) begin failures++; $display("FAIL basic_claim_id: got %0d expected 2", irq_id); end
        complete = 1'b1; complete_id = 3'd2; intr = 8'h0C;
        tick();
        complete = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_complete_busy: got %0b expected 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_complete_err: got %0b expected 0", err); end
        tick();
        // rr_ptr is 3 now, so source 3 wins the tie against source 2
        checks++; if (irq_id !== 3'd3) begin failures++; $display("FAIL basic_rr_id: got %0d expected 3", irq_id); end
        claim = 1'b1;
        tick();
        claim = 1'b0; complete = 1'b1; complete_id = 3'd3; intr = 8'h00;
        tick();
        complete = 1'b0;
        tick();
    endtask

    task automatic test_prio();
        prio = 16'hC001;
        intr = 8'h81;
        tick();
        checks++; if (irq_id !== 3'd7) begin failures++; $display("FAIL prio_id_first: got %0d expected 7", irq_id); end
        claim = 1'b1;
        tick();
        claim = 1'b0; complete = 1'b1; complete_id = 3'd7;
        tick();
        complete = 1'b0;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prio_irq_again: got %0b expected 1", irq); end
        checks++; if (irq_id !== 3'd7) begin failures++; $display("FAIL prio_id_again: got %0d expected 7", irq_id); end
        claim = 1'b1;
        tick();
        claim = 1'b0; complete = 1'b1; complete_id = 3'd7; intr = 8'h00;
        tick();
        complete = 1'b0; prio = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [IdW-1:0] exp_id;
        intr = 8'h0F;
        for (int r = 0; r < 4; r++) begin
            exp_id = IdW'(r);
            tick();
            checks++; if (irq_id !== exp_id) begin failures++; $display("FAIL rr_round%0d: got %0d expected %0d", r, irq_id, exp_id); end
            claim = 1'b1;
            tick();
            claim = 1'b0; complete = 1'b1; complete_id = exp_id;
            tick();
            complete = 1'b0;
        end
        intr = 8'h00;
        tick();
    endtask

    task automatic test_coalesce();
        logic exp_irq;
        logic seen;
        coal = 8'd5;
        intr = 8'h02;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_irq = (i == 5);
            checks++; if (irq !== exp_irq) begin failures++; $display("FAIL coal_cycle%0d: got %0b expected %0b", i, irq, exp_irq); end
        end
        checks++; if (irq_id !== 3'd1) begin failures++; $display("FAIL coal_id: got %0d expected 1", irq_id); end
        intr = 8'h00;
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL coal_drop_pend: got %0b expected 0", irq); end
        intr = 8'h02;
        tick(); tick();
        intr = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | irq;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL coal_abort: got %0b expected 0", seen); end
        coal = 8'd0;
    endtask

    task automatic test_errors();
        claim = 1'b1;
        tick();
        claim = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_idle_claim: got %0b expected 1", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_idle_busy: got %0b expected 0", busy); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_single_pulse: got %0b expected 0", err); end
        intr = 8'h08;
        tick();
        claim = 1'b1;
        tick();
        claim = 1'b0; complete = 1'b1; complete_id = 3'd5;
        tick();
        complete = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_bad_id: got %0b expected 1", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL err_bad_id_busy: got %0b expected 1", busy); end
        checks++; if (irq_id !== 3'd3) begin failures++; $display("FAIL err_bad_id_hold: got %0d expected 3", irq_id); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_bad_id_clear: got %0b expected 0", err); end
        // claim and complete together in CLAIMED: claim is an error, complete is valid
        claim = 1'b1; complete = 1'b1; complete_id = 3'd3; intr = 8'h00;
        tick();
        claim = 1'b0; complete = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_both_err: got %0b expected 1", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_both_busy: got %0b expected 0", busy); end
        tick();
    endtask

    task automatic test_claim_on_drop();
        intr = 8'h10;
        tick();
        intr = 8'h00; claim = 1'b1;
        tick();
        claim = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_claim_busy: got %0b expected 1", busy); end
        checks++; if (irq_id !== 3'd4) begin failures++; $display("FAIL drop_claim_id: got %0d expected 4", irq_id); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL drop_claim_err: got %0b expected 0", err); end
        complete = 1'b1; complete_id = 3'd4;
        tick();
        complete = 1'b0;
        tick();
    endtask

    task automatic test_reset_claimed();
        intr = 8'h20;
        tick();
        claim = 1'b1;
        tick();
        claim = 1'b0; intr = 8'h00;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
        checks++; if (irq_id !== 3'd0) begin failures++; $display("FAIL rst_mid_id: got %0d expected 0", irq_id); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq: got %0b expected 0", irq); end
        tick();
        rst = 1'b0; intr = 8'h21;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rst_after_irq: got %0b expected 1", irq); end
        checks++; if (irq_id !== 3'd0) begin failures++; $display("FAIL rst_after_id: got %0d expected 0", irq_id); end
        intr = 8'h00;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_prio();
        test_round_robin();
        test_coalesce();
        test_errors();
        test_claim_on_drop();
        test_reset_claimed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
